// File: rtl/seven_seg_scanner_pkg.sv
// ----------------------------------------------------------------------------
// seven_seg_scanner_pkg
//   Shared definitions for the multiplexed 7-segment scanner: scan FSM state
//   encoding, segment bus width and the all-segments-off code.
//   No ports (package).
//   Optional feature macro used elsewhere in this slice: SEG_DP_EN.
// ----------------------------------------------------------------------------
package seven_seg_scanner_pkg;

    localparam int SEG_W = 7;

    // Active-low segments: all ones turns every segment off.
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_t;

endpackage

// File: rtl/seven_seg_scanner_if.sv
// ----------------------------------------------------------------------------
// seven_seg_scanner_if
//   Control/load bus of the scanner.
//   enable    : 1 = scan, 0 = display dark
//   seg_in    : packed per-digit active-low codes, digit k at [7k+6:7k]
//   dp_in     : per-digit active-low decimal points (only with SEG_DP_EN)
//   load      : one-cycle request to capture seg_in (and dp_in)
//   load_ack  : one-cycle pulse when the captured codes take over the display
//   master modport drives the bus, slave modport is the scanner.
// ----------------------------------------------------------------------------
interface seven_seg_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    import seven_seg_scanner_pkg::*;

    logic                        enable;
    logic [SEG_W*NUM_DIGITS-1:0] seg_in;
    logic                        load;
    logic                        load_ack;
`ifdef SEG_DP_EN
    logic [NUM_DIGITS-1:0]       dp_in;

    modport master (output enable, output seg_in, output dp_in, output load, input load_ack);
    modport slave  (input enable, input seg_in, input dp_in, input load, output load_ack);
`else
    modport master (output enable, output seg_in, output load, input load_ack);
    modport slave  (input enable, input seg_in, input load, output load_ack);
`endif

endinterface

// File: rtl/seven_seg_scanner_scan_timer.sv
// ----------------------------------------------------------------------------
// scan_timer
//   Slot counter for the display scanner. Counts 0..REFRESH_DIV-1 while run
//   is high and is held at zero otherwise.
//   Clk        : system clock, rising edge
//   Rst_n      : asynchronous reset, active-low
//   run        : count enable; low clears the counter
//   blank_done : count is on the last blanking cycle of the slot
//   slot_done  : count is on the last cycle of the slot
// ----------------------------------------------------------------------------
module scan_timer #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic run,
    output logic blank_done,
    output logic slot_done
);
    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt <= '0;
        end else if (!run || slot_done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign blank_done = (cnt == CNT_W'(BLANK_CYCLES - 1));
    assign slot_done  = (cnt == CNT_W'(REFRESH_DIV - 1));

endmodule

// File: rtl/seven_seg_scanner.sv
// ----------------------------------------------------------------------------
// seven_seg_scanner
//   Time-multiplexes NUM_DIGITS active-low segment codes onto one shared
//   common-anode cathode bus. Every digit slot begins with BLANK_CYCLES of
//   all-anodes-off to prevent ghosting. New codes are double-buffered and
//   only take over the display at a frame start (digit 0 slot begins).
//   Optional macro SEG_DP_EN adds per-digit decimal point input and dp_out.
// Ports
//   Clk        : system clock, rising edge
//   Rst_n      : asynchronous reset, active-low
//   bus        : seven_seg_scanner_if.slave (enable, seg_in, [dp_in], load, load_ack)
//   seg_out    : shared cathodes, active-low, bit6=a .. bit0=g
//   an_out     : anode enables, active-low, at most one low
//   digit_idx  : digit owning the current slot
//   dp_out     : decimal point, active-low (only with SEG_DP_EN)
// ----------------------------------------------------------------------------
module seven_seg_scanner
    import seven_seg_scanner_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic                          Clk,
    input  logic                          Rst_n,
    seven_seg_scanner_if.slave            bus,
    output logic [SEG_W-1:0]              seg_out,
    output logic [NUM_DIGITS-1:0]         an_out,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
`ifdef SEG_DP_EN
    ,
    output logic                          dp_out
`endif
);
    localparam int                IDX_W    = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam int                BUF_W    = SEG_W * NUM_DIGITS;

    scan_state_t      state;
    logic [BUF_W-1:0] pend_seg;
    logic [BUF_W-1:0] disp_seg;
    logic             pend_valid;
    logic             run;
    logic             blank_done;
    logic             slot_done;
    logic             frame_start;
`ifdef SEG_DP_EN
    logic [NUM_DIGITS-1:0] pend_dp;
    logic [NUM_DIGITS-1:0] disp_dp;
`endif

    // A frame starts when scanning begins from IDLE or when the last digit's
    // slot rolls over to digit 0. A falling enable overrides both.
    assign run         = (state != ST_IDLE) && bus.enable;
    assign frame_start = bus.enable &&
                         ((state == ST_IDLE) ||
                          (state == ST_SHOW && slot_done && digit_idx == LAST_IDX));

    scan_timer #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .run        (run),
        .blank_done (blank_done),
        .slot_done  (slot_done)
    );

    // Pending/display double buffer. The swap reads the old pending value, so a
    // load on the frame-start edge lands in pending and waits a whole frame.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pend_seg     <= {NUM_DIGITS{SEG_BLANK}};
            disp_seg     <= {NUM_DIGITS{SEG_BLANK}};
            pend_valid   <= 1'b0;
            bus.load_ack <= 1'b0;
`ifdef SEG_DP_EN
            pend_dp      <= '1;
            disp_dp      <= '1;
`endif
        end else begin
            bus.load_ack <= frame_start && pend_valid;
            if (frame_start && pend_valid) begin
                disp_seg   <= pend_seg;
                pend_valid <= 1'b0;
`ifdef SEG_DP_EN
                disp_dp    <= pend_dp;
`endif
            end
            if (bus.load) begin
                pend_seg   <= bus.seg_in;
                pend_valid <= 1'b1;
`ifdef SEG_DP_EN
                pend_dp    <= bus.dp_in;
`endif
            end
        end
    end

    // Scan FSM with registered outputs. The display buffer only changes at a
    // frame start, which is always in a BLANK slot, so latching the code on
    // SHOW entry is tear-free.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= ST_IDLE;
            seg_out   <= SEG_BLANK;
            an_out    <= '1;
            digit_idx <= '0;
`ifdef SEG_DP_EN
            dp_out    <= 1'b1;
`endif
        end else if (state != ST_IDLE && !bus.enable) begin
            state     <= ST_IDLE;
            seg_out   <= SEG_BLANK;
            an_out    <= '1;
            digit_idx <= '0;
`ifdef SEG_DP_EN
            dp_out    <= 1'b1;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.enable) begin
                        state     <= ST_BLANK;
                        digit_idx <= '0;
                    end
                end
                ST_BLANK: begin
                    if (blank_done) begin
                        state   <= ST_SHOW;
                        an_out  <= ~(NUM_DIGITS'(1) << digit_idx);
                        seg_out <= disp_seg[SEG_W*int'(digit_idx) +: SEG_W];
`ifdef SEG_DP_EN
                        dp_out  <= disp_dp[digit_idx];
`endif
                    end
                end
                ST_SHOW: begin
                    if (slot_done) begin
                        state     <= ST_BLANK;
                        an_out    <= '1;
                        seg_out   <= SEG_BLANK;
                        digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
`ifdef SEG_DP_EN
                        dp_out    <= 1'b1;
`endif
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    an_out  <= '1;
                    seg_out <= SEG_BLANK;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// ----------------------------------------------------------------------------
// tb_seven_seg_scanner
//   Self-checking bench for seven_seg_scanner (NUM_DIGITS=4, REFRESH_DIV=8,
//   BLANK_CYCLES=2). A time-position model (cycles since scan start) gives the
//   expected outputs every cycle; directed literal checks pin the model.
//   Honours SEG_DP_EN.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seven_seg_scanner;
    import seven_seg_scanner_pkg::*;

    localparam int N     = 4;
    localparam int R     = 8;
    localparam int B     = 2;
    localparam int FRAME = N * R;

    logic         Clk   = 1'b0;
    logic         Rst_n = 1'b0;
    logic [6:0]   seg_out;
    logic [N-1:0] an_out;
    logic [1:0]   digit_idx;
`ifdef SEG_DP_EN
    logic         dp_out;
`endif

    seven_seg_scanner_if #(.NUM_DIGITS(N)) bus ();

    seven_seg_scanner #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (R),
        .BLANK_CYCLES (B)
    ) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .bus       (bus),
        .seg_out   (seg_out),
        .an_out    (an_out),
        .digit_idx (digit_idx)
`ifdef SEG_DP_EN
        ,
        .dp_out    (dp_out)
`endif
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    bit         running;
    int         t;
    logic [6:0] m_disp [N];
    logic [6:0] m_pend [N];
    bit         m_pv;
    logic       m_ack;
    logic       m_dpd  [N];
    logic       m_dpp  [N];

    always @(posedge Clk or negedge Rst_n) begin
        bit fs;
        fs = 1'b0;
        if (!Rst_n) begin
            running = 1'b0;
            t       = 0;
            m_pv    = 1'b0;
            m_ack   = 1'b0;
            for (int k = 0; k < N; k++) begin
                m_disp[k] = 7'h7F; m_pend[k] = 7'h7F;
                m_dpd[k]  = 1'b1;  m_dpp[k]  = 1'b1;
            end
        end else begin
            if (!running) begin
                if (bus.enable) begin running = 1'b1; t = 0; fs = 1'b1; end
            end else if (!bus.enable) begin
                running = 1'b0;
            end else begin
                t  = t + 1;
                fs = ((t % FRAME) == 0);
            end
            m_ack = fs && m_pv;
            if (fs && m_pv) begin
                for (int k = 0; k < N; k++) begin m_disp[k] = m_pend[k]; m_dpd[k] = m_dpp[k]; end
                m_pv = 1'b0;
            end
            if (bus.load) begin
                for (int k = 0; k < N; k++) begin
                    m_pend[k] = bus.seg_in[7*k +: 7];
`ifdef SEG_DP_EN
                    m_dpp[k]  = bus.dp_in[k];
`endif
                end
                m_pv = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge Clk) begin
        logic [6:0]   e_seg;
        logic [N-1:0] e_an;
        int           e_idx;
        logic         e_dp;
        int           pos;
        int           d;
        if (cmp_en) begin
            e_seg = 7'h7F; e_an = '1; e_idx = 0; e_dp = 1'b1;
            if (running) begin
                pos   = t % R;
                d     = (t / R) % N;
                e_idx = d;
                if (pos >= B) begin
                    e_an  = ~(N'(1) << d);
                    e_seg = m_disp[d];
                    e_dp  = m_dpd[d];
                end
            end
            check("seg_out", 32'(seg_out), 32'(e_seg));
            check("an_out", 32'(an_out), 32'(e_an));
            check("digit_idx", 32'(digit_idx), 32'(e_idx));
            check("load_ack", 32'(bus.load_ack), 32'(m_ack));
`ifdef SEG_DP_EN
            check("dp_out", 32'(dp_out), 32'(e_dp));
`else
            if (e_dp !== 1'b1) check("dp_model", 32'(e_dp), 32'd1);
`endif
        end
    end

    task automatic steps(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // ---------------- stimulus + literal checks ----------------
    logic [27:0] codes;

    initial begin
        bus.enable = 1'b0;
        bus.load   = 1'b0;
        bus.seg_in = '0;
`ifdef SEG_DP_EN
        bus.dp_in  = '1;
`endif
        steps(3);
        Rst_n  = 1'b1;
        cmp_en = 1'b1;
        check("rst_seg", 32'(seg_out), 32'h7F);
        check("rst_an", 32'(an_out), 32'hF);
        check("rst_idx", 32'(digit_idx), 32'd0);
        check("rst_ack", 32'(bus.load_ack), 32'd0);

        // load in IDLE, then enable: ack on the frame-start edge
        steps(1);
        codes      = {7'h79, 7'h12, 7'h24, 7'h40};
        bus.seg_in = codes;
        bus.load   = 1'b1;
`ifdef SEG_DP_EN
        bus.dp_in  = 4'b1011;
`endif
        steps(1);
        bus.load   = 1'b0;
        bus.enable = 1'b1;
        steps(1);                                 // t=0
        check("first_ack", 32'(bus.load_ack), 32'd1);
        check("first_blank_an", 32'(an_out), 32'hF);
        steps(2);                                 // t=2
        check("d0_an", 32'(an_out), 32'hE);
        check("d0_seg", 32'(seg_out), 32'h40);
`ifdef SEG_DP_EN
        check("d0_dp", 32'(dp_out), 32'd1);
`endif
        steps(6);                                 // t=8
        check("d1_blank_an", 32'(an_out), 32'hF);
        check("d1_blank_idx", 32'(digit_idx), 32'd1);
        steps(2);                                 // t=10
        check("d1_an", 32'(an_out), 32'hD);
        check("d1_seg", 32'(seg_out), 32'h24);
        steps(6);                                 // t=16
`ifdef SEG_DP_EN
        check("d2_blank_dp", 32'(dp_out), 32'd1);
`endif
        steps(2);                                 // t=18
        check("d2_an", 32'(an_out), 32'hB);
        check("d2_seg", 32'(seg_out), 32'h12);
`ifdef SEG_DP_EN
        check("d2_dp", 32'(dp_out), 32'd0);
`endif
        steps(13);                                // t=31
        check("d3_idx", 32'(digit_idx), 32'd3);
        check("d3_seg", 32'(seg_out), 32'h79);
        steps(1);                                 // t=32
        check("wrap_idx", 32'(digit_idx), 32'd0);
        check("no_ack_idle_frame", 32'(bus.load_ack), 32'd0);

        // two loads in one frame -> one ack, last value wins
        codes[6:0] = 7'h01; bus.seg_in = codes; bus.load = 1'b1;
        steps(1); bus.load = 1'b0;                // t=33
        steps(7);                                 // t=40
        codes[6:0] = 7'h4F; bus.seg_in = codes; bus.load = 1'b1;
        steps(1); bus.load = 1'b0;                // t=41
        steps(23);                                // t=64
        check("dbl_ack", 32'(bus.load_ack), 32'd1);
        steps(1);
        check("dbl_ack_once", 32'(bus.load_ack), 32'd0);
        steps(1);                                 // t=66
        check("dbl_seg", 32'(seg_out), 32'h4F);

        // load on the frame-start edge is deferred a frame
        steps(29);                                // t=95
        codes[6:0] = 7'h00; bus.seg_in = codes; bus.load = 1'b1;
        steps(1); bus.load = 1'b0;                // t=96
        check("edge_no_ack", 32'(bus.load_ack), 32'd0);
        steps(2);                                 // t=98
        check("edge_old_seg", 32'(seg_out), 32'h4F);
        steps(30);                                // t=128
        check("edge_ack", 32'(bus.load_ack), 32'd1);
        steps(2);                                 // t=130
        check("edge_new_seg", 32'(seg_out), 32'h00);

        // enable dropped mid-SHOW of digit 2
        steps(18);                                // t=148
        check("drop_pre_an", 32'(an_out), 32'hB);
        bus.enable = 1'b0;
        steps(1);
        check("drop_an", 32'(an_out), 32'hF);
        check("drop_seg", 32'(seg_out), 32'h7F);
        check("drop_idx", 32'(digit_idx), 32'd0);
        codes[6:0] = 7'h12; bus.seg_in = codes; bus.load = 1'b1;
        steps(1); bus.load = 1'b0;
        steps(2);
        bus.enable = 1'b1;
        steps(1);                                 // t=0
        check("reen_ack", 32'(bus.load_ack), 32'd1);
        check("reen_an", 32'(an_out), 32'hF);
        steps(2);                                 // t=2
        check("reen_an_show", 32'(an_out), 32'hE);
        check("reen_seg", 32'(seg_out), 32'h12);
        steps(1);                                 // t=3, mid-SHOW

        // asynchronous reset mid-SHOW
        #2 Rst_n = 1'b0;
        #1;
        check("arst_seg", 32'(seg_out), 32'h7F);
        check("arst_an", 32'(an_out), 32'hF);
        check("arst_ack", 32'(bus.load_ack), 32'd0);
        check("arst_idx", 32'(digit_idx), 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge Clk);
            bus.enable = ($urandom_range(0, 199) != 0);
            bus.load   = ($urandom_range(0, 19) == 0);
            bus.seg_in = 28'($urandom);
`ifdef SEG_DP_EN
            bus.dp_in  = 4'($urandom);
`endif
        end
        bus.load = 1'b0;
        steps(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
